// File: rtl/lcd_pkg.sv
// Shared types, command constants and the power-on init ROM for the
// HD44780-style character LCD sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRON,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } state_e;

  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] HOME         = 8'h02;
  localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] ENTRY_INC    = 8'h06;

  localparam int INIT_LEN = 4;

  // Entry 0 sits in the least-significant byte and is issued first.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {ENTRY_INC, CLEAR, DISP_ON, FUNC_8BIT_2L};

  // Clear/home (0x03 also decodes as home) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR || data == HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Character LCD write sequencer: runs power-on init, then converts accepted
// byte writes into setup / EN pulse / hold / execution-wait bus cycles.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERON   = 750000,
  parameter int T_SETUP     = 3,
  parameter int T_PULSE     = 13,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_vld,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_rdy,
  input  logic       i_reinit,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  // Timer holds "cycles remaining minus one", so a state of length N
  // loads N-1 and leaves when the count reaches zero.
  localparam logic [CNT_W-1:0] LD_PWRON = CNT_W'(T_POWERON - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             on_q;
  logic             tmr_zero;

  assign tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = done_q;

    if (state_q != IDLE && !tmr_zero) begin
      tmr_d = tmr_q - CNT_W'(1);
    end

    case (state_q)
      PWRON: begin
        if (tmr_zero) begin
          state_d = SETUP;
          tmr_d   = LD_SETUP;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = INIT_ROM[0];
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d = PULSE;
          tmr_d   = LD_PULSE;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d = HOLD;
          tmr_d   = LD_HOLD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = EXEC;
          tmr_d   = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
        end
      end
      EXEC: begin
        if (tmr_zero) begin
          if (done_q) begin
            state_d = IDLE;
          end else if (idx_q == 2'(INIT_LEN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            tmr_d   = LD_SETUP;
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = INIT_ROM[idx_q + 2'd1];
          end
        end
      end
      IDLE: begin
        // Reinit beats a simultaneous request; o_cmd_rdy is already low then.
        if (i_reinit) begin
          state_d = PWRON;
          tmr_d   = LD_PWRON;
          idx_d   = 2'd0;
          done_d  = 1'b0;
        end else if (i_cmd_vld) begin
          state_d = SETUP;
          tmr_d   = LD_SETUP;
          rs_d    = i_cmd_rs;
          data_d  = i_cmd_data;
        end
      end
      default: begin
        state_d = PWRON;
        tmr_d   = LD_PWRON;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PWRON;
      tmr_q   <= LD_PWRON;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      on_q    <= 1'b1;
    end
  end

  assign o_cmd_rdy   = (state_q == IDLE) && !i_reinit;
  assign o_init_done = done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = (state_q == PULSE);
  assign o_lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing overrides: init trace table,
// write latencies, back-to-back handshakes, reinit priority and mid-op reset.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       i_rst, i_cmd_vld, i_cmd_rs, i_reinit;
  logic [7:0] i_cmd_data;
  logic       o_cmd_rdy, o_init_done, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [7:0] o_lcd_data;

  int checks = 0;
  int errors = 0;
  int rw_bad = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_POWERON(10), .T_SETUP(2), .T_PULSE(3), .T_HOLD(1),
    .T_EXEC(5), .T_EXEC_LONG(20), .CNT_W(20)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_vld(i_cmd_vld), .i_cmd_rs(i_cmd_rs), .i_cmd_data(i_cmd_data),
    .o_cmd_rdy(o_cmd_rdy), .i_reinit(i_reinit), .o_init_done(o_init_done),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
  );

  always @(negedge clk) if (o_lcd_rw !== 1'b0) rw_bad++;

  typedef struct {
    int         cyc;
    logic       en;
    logic       rs;
    logic [7:0] data;
    logic       rdy;
    logic       done;
    logic       on;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts in cycle 0 (first cycle after reset/reinit) and runs until rdy.
  task automatic run_init(input bit use_tbl, input bit hold_vld,
                          output int rdy_cyc, output int rises, output int bad_w);
    int   ti;
    int   w;
    logic prev_en;
    ti = 0; w = 0; prev_en = 1'b0;
    rises = 0; bad_w = 0; rdy_cyc = -1;
    i_cmd_vld = hold_vld; i_cmd_rs = 1'b1; i_cmd_data = 8'hAA;
    for (int c = 0; c < 200; c++) begin
      if (use_tbl && ti < NV && tbl[ti].cyc == c) begin
        chk($sformatf("init c%0d en", c),   32'(o_lcd_en),    32'(tbl[ti].en));
        chk($sformatf("init c%0d rs", c),   32'(o_lcd_rs),    32'(tbl[ti].rs));
        chk($sformatf("init c%0d data", c), 32'(o_lcd_data),  32'(tbl[ti].data));
        chk($sformatf("init c%0d rdy", c),  32'(o_cmd_rdy),   32'(tbl[ti].rdy));
        chk($sformatf("init c%0d done", c), 32'(o_init_done), 32'(tbl[ti].done));
        chk($sformatf("init c%0d on", c),   32'(o_lcd_on),    32'(tbl[ti].on));
        ti++;
      end
      if (o_lcd_en && !prev_en) rises++;
      if (o_lcd_en) w++;
      else begin
        if (prev_en && w != 3) bad_w++;
        w = 0;
      end
      prev_en = o_lcd_en;
      if (o_cmd_rdy) begin
        rdy_cyc = c;
        i_cmd_vld = 1'b0;
        break;
      end
      step;
    end
    i_cmd_vld = 1'b0;
    if (use_tbl) chk("init table reached", 32'(ti), 32'(NV));
  endtask

  // Issues one write from IDLE; low = cycles rdy stays low, mask[k] = EN at
  // k cycles after accept, bad = cycles where rs/data differ from the write.
  task automatic write_meas(input logic rs, input logic [7:0] d,
                            output int low, output logic [31:0] mask, output int bad);
    mask = '0; bad = 0; low = -1;
    chk("accept rdy", 32'(o_cmd_rdy), 32'd1);
    i_cmd_vld = 1'b1; i_cmd_rs = rs; i_cmd_data = d;
    step;
    i_cmd_vld = 1'b0; i_cmd_data = 8'h00; i_cmd_rs = 1'b0;
    for (int k = 1; k < 60; k++) begin
      if (o_cmd_rdy) begin
        low = k - 1;
        break;
      end
      mask[k] = o_lcd_en;
      if (o_lcd_data !== d || o_lcd_rs !== rs) bad++;
      step;
    end
  endtask

  initial begin
    int          rdy_cyc, rises, bad_w, low, bad, n, w, maxw;
    int          acc[3];
    logic [31:0] mask;
    logic [7:0]  bytes[3];
    logic        prev_en, accepted;

    //         cyc en rs data   rdy done on
    tbl[0]  = '{1,  0, 0, 8'h00, 0, 0, 1};
    tbl[1]  = '{9,  0, 0, 8'h00, 0, 0, 1};
    tbl[2]  = '{10, 0, 0, 8'h38, 0, 0, 1};
    tbl[3]  = '{11, 0, 0, 8'h38, 0, 0, 1};
    tbl[4]  = '{12, 1, 0, 8'h38, 0, 0, 1};
    tbl[5]  = '{14, 1, 0, 8'h38, 0, 0, 1};
    tbl[6]  = '{15, 0, 0, 8'h38, 0, 0, 1};
    tbl[7]  = '{20, 0, 0, 8'h38, 0, 0, 1};
    tbl[8]  = '{21, 0, 0, 8'h0C, 0, 0, 1};
    tbl[9]  = '{23, 1, 0, 8'h0C, 0, 0, 1};
    tbl[10] = '{26, 0, 0, 8'h0C, 0, 0, 1};
    tbl[11] = '{32, 0, 0, 8'h01, 0, 0, 1};
    tbl[12] = '{34, 1, 0, 8'h01, 0, 0, 1};
    tbl[13] = '{36, 1, 0, 8'h01, 0, 0, 1};
    tbl[14] = '{37, 0, 0, 8'h01, 0, 0, 1};
    tbl[15] = '{57, 0, 0, 8'h01, 0, 0, 1};
    tbl[16] = '{58, 0, 0, 8'h06, 0, 0, 1};
    tbl[17] = '{60, 1, 0, 8'h06, 0, 0, 1};
    tbl[18] = '{62, 1, 0, 8'h06, 0, 0, 1};
    tbl[19] = '{63, 0, 0, 8'h06, 0, 0, 1};
    tbl[20] = '{68, 0, 0, 8'h06, 0, 0, 1};
    tbl[21] = '{69, 0, 0, 8'h06, 1, 1, 1};

    i_rst = 1'b1; i_cmd_vld = 1'b0; i_cmd_rs = 1'b0; i_cmd_data = 8'h00; i_reinit = 1'b0;
    step; step; step;
    chk("reset en",   32'(o_lcd_en),    32'd0);
    chk("reset data", 32'(o_lcd_data),  32'd0);
    chk("reset rs",   32'(o_lcd_rs),    32'd0);
    chk("reset rdy",  32'(o_cmd_rdy),   32'd0);
    chk("reset done", 32'(o_init_done), 32'd0);
    chk("reset on",   32'(o_lcd_on),    32'd0);
    i_rst = 1'b0;

    // Requester holds vld through init; nothing may be accepted.
    run_init(1'b1, 1'b1, rdy_cyc, rises, bad_w);
    chk("init rdy cycle", 32'(rdy_cyc), 32'd69);
    chk("init en pulses", 32'(rises), 32'd4);
    chk("init en width",  32'(bad_w), 32'd0);

    write_meas(1'b1, 8'h41, low, mask, bad);
    chk("data rdy low", 32'(low), 32'd11);
    chk("data en mask", mask, 32'h38);
    chk("data stable",  32'(bad), 32'd0);
    chk("data after",   32'(o_lcd_data), 32'h41);
    chk("rs after",     32'(o_lcd_rs), 32'd1);

    write_meas(1'b0, 8'h01, low, mask, bad);
    chk("clear rdy low", 32'(low), 32'd26);
    chk("clear en mask", mask, 32'h38);
    write_meas(1'b1, 8'h01, low, mask, bad);
    chk("data01 rdy low", 32'(low), 32'd11);
    write_meas(1'b0, 8'h02, low, mask, bad);
    chk("home rdy low", 32'(low), 32'd26);
    write_meas(1'b0, 8'h04, low, mask, bad);
    chk("instr04 rdy low", 32'(low), 32'd11);

    // Back-to-back with vld held high.
    bytes[0] = 8'h48; bytes[1] = 8'h49; bytes[2] = 8'h4A;
    n = 0; rises = 0; w = 0; maxw = 0; prev_en = 1'b0;
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    i_cmd_vld = 1'b1; i_cmd_rs = 1'b1; i_cmd_data = bytes[0];
    for (int c = 0; c < 45; c++) begin
      if (o_lcd_en && !prev_en) rises++;
      w = o_lcd_en ? w + 1 : 0;
      if (w > maxw) maxw = w;
      prev_en = o_lcd_en;
      accepted = o_cmd_rdy && i_cmd_vld;
      step;
      if (accepted) begin
        acc[n] = c;
        n++;
        if (n < 3) i_cmd_data = bytes[n];
        else i_cmd_vld = 1'b0;
      end
    end
    chk("b2b accepts",   32'(n), 32'd3);
    chk("b2b gap 0-1",   32'(acc[1] - acc[0] - 1), 32'd11);
    chk("b2b gap 1-2",   32'(acc[2] - acc[1] - 1), 32'd11);
    chk("b2b en pulses", 32'(rises), 32'd3);
    chk("b2b en width",  32'(maxw), 32'd3);
    chk("b2b last data", 32'(o_lcd_data), 32'h4A);

    // Reinit and a request in the same IDLE cycle.
    chk("pre-reinit rdy", 32'(o_cmd_rdy), 32'd1);
    i_cmd_vld = 1'b1; i_cmd_rs = 1'b0; i_cmd_data = 8'h55; i_reinit = 1'b1;
    #1;
    chk("reinit rdy", 32'(o_cmd_rdy), 32'd0);
    step;
    i_cmd_vld = 1'b0; i_reinit = 1'b0;
    chk("reinit done drop", 32'(o_init_done), 32'd0);
    chk("reinit no capture", 32'(o_lcd_data), 32'h4A);
    run_init(1'b0, 1'b0, rdy_cyc, rises, bad_w);
    chk("reinit rdy cycle", 32'(rdy_cyc), 32'd69);
    chk("reinit en pulses", 32'(rises), 32'd4);

    // Reset while EN is high.
    i_cmd_vld = 1'b1; i_cmd_rs = 1'b1; i_cmd_data = 8'h5A;
    step;
    i_cmd_vld = 1'b0;
    step; step;
    chk("midrst en high", 32'(o_lcd_en), 32'd1);
    i_rst = 1'b1;
    step;
    chk("midrst en",   32'(o_lcd_en),    32'd0);
    chk("midrst data", 32'(o_lcd_data),  32'd0);
    chk("midrst rs",   32'(o_lcd_rs),    32'd0);
    chk("midrst rdy",  32'(o_cmd_rdy),   32'd0);
    chk("midrst done", 32'(o_init_done), 32'd0);
    chk("midrst on",   32'(o_lcd_on),    32'd0);
    i_rst = 1'b0;
    run_init(1'b0, 1'b0, rdy_cyc, rises, bad_w);
    chk("midrst rdy cycle", 32'(rdy_cyc), 32'd69);
    chk("midrst en pulses", 32'(rises), 32'd4);

    chk("rw always low", 32'(rw_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
